signed_cnt_seq: RTL and testbench
=================================

Name: signed_cnt_seq

Overview:
- Controller that sequences a signed up-counter.
- Accepts a start/end/step/repeat program and steps the counter from start to end, repeating the pass N times.
- Provides pause and abort controls and busy/done/err status.
- Sits between a control FSM or register block and the signed count output consumed by downstream logic.

Parameters:
- WIDTH, 4, bit width of the signed count and of the start/end bounds.
- REP_W, 3, bit width of the repeat count and the pass counter.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low clear.
- start  in  1  program request; sampled only in IDLE.
- cfg_start  in  WIDTH  signed first value of each pass.
- cfg_end  in  WIDTH  signed last allowed value of each pass.
- cfg_step  in  WIDTH-1  unsigned increment; 0 is treated as 1.
- cfg_rep  in  REP_W  number of passes; 0 is treated as 1.
- pause  in  1  freezes the count while in RUN.
- abort  in  1  terminates the sequence.
- q  out  WIDTH  signed count value.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on a rejected program.
- pass_cnt  out  REP_W  completed passes in the current or last run.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on clr_n; all state clears immediately on assertion.
- Reset values: state=IDLE, q=0, busy=0, done=0, err=0, pass_cnt=0.
- All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with cfg_end >= cfg_start (signed compare): latch cfg_*; at the same edge q<=cfg_start, pass_cnt<=0, busy<=1, state RUN. Latency from start to first value is 1 edge.
  - start=1 with cfg_end < cfg_start: err pulses for 1 cycle, state stays IDLE, q unchanged.
- RUN, each edge, in priority order:
  1. abort=1: state IDLE, busy<=0, q and pass_cnt hold, no done pulse.
  2. pause=1: hold everything.
  3. Else compute nxt = q + step in WIDTH+1-bit signed arithmetic, so no overflow wrap is possible.
  4. If nxt <= end: q<=nxt.
  5. Otherwise the pass is complete: pass_cnt<=pass_cnt+1.
     - If pass_cnt+1 == rep: state DONE, busy<=0, done<=1, q holds the last value.
     - Else q<=latched start and counting continues with no bubble cycle.
- Step overshoot: the counter never exceeds end. Example: start=-3, end=2, step=2 gives -3,-1,1.
- start=end: each pass is a single cycle.
- Full range: start=-8, end=7, step=1 (WIDTH=4) covers all 16 values with no wrap.
- DONE: lasts exactly 1 cycle with done=1, then IDLE. start is ignored during DONE.
- cfg_* changes while busy have no effect, because the program is latched at start.
- start while busy is ignored.
- abort takes priority over pause. abort in IDLE or DONE is ignored.
- clr_n asserted mid-run: immediate return to reset values.

Optional Feature:
SIGNED_CNT_SEQ_DOWN_EN
- Defined:
  - Adds input port dir (1 bit), latched at start.
  - dir=1 counts downward: nxt = q - step; valid program requires cfg_end <= cfg_start; the pass ends when nxt < end.
  - dir=0 behaves exactly as the undefined build.
- Undefined: no dir port; up-count only.

Decomposition:
- Shared package: state typedef (IDLE/RUN/DONE), default WIDTH/REP_W constants, helper function for the WIDTH+1 signed bound compare.
- One natural sub-module, signed_cnt_core: a loadable signed counter with load, en, load_val, step and q. The sequencer FSM drives load/en into it.

Test Plan:
- Reset: clr_n=0 asserted asynchronously mid-RUN -> q=0, busy=0, pass_cnt=0 immediately, before the next clock.
- Basic run: start=-3, end=2, step=2, rep=1 -> q=-3,-1,1 on successive edges; done pulse 1 cycle; busy low; pass_cnt=1.
- Repeat with pause: rep=2, same program, pause high for 3 cycles after q=-1 -> q holds -1 for 3 cycles; then -1,1,-3,-1,1; done; pass_cnt=2.
- Full range and zero step: start=-8, end=7, step=0 (treated as 1), rep=0 (treated as 1) -> 16 values -8..7, no wrap, done.
- Error and abort:
  - end=-5, start=3 -> err pulse, busy stays 0.
  - Valid run aborted at q=0 -> IDLE, q=0 held, no done.
- Down-count (macro defined): dir=1, start=5, end=-4, step=3 -> q=5,2,-1,-4, done.

Source files
------------

// File: rtl/signed_cnt_seq_pkg.sv
// Shared types and helpers for the signed count sequencer.
// Optional build macro: SIGNED_CNT_SEQ_DOWN_EN (adds down-count direction).
package signed_cnt_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_REP_W = 3;

  // Bound compares are done on values sign-extended to this width so any
  // WIDTH+1-bit candidate fits without wrap.
  localparam int CMP_W = 33;

  // True when val lies beyond lim in the counting direction:
  // above lim when counting up, below lim when counting down.
  function automatic logic past_end(input logic signed [CMP_W-1:0] val,
                                    input logic signed [CMP_W-1:0] lim,
                                    input logic                    down);
    past_end = down ? (val < lim) : (val > lim);
  endfunction

endpackage

// File: rtl/signed_cnt_seq_cnt_core.sv
// Loadable signed counter. load has priority over en. nxt is the WIDTH+1-bit
// signed candidate (q +/- step) so the sequencer can bound-check it before
// enabling the update; only the low WIDTH bits are ever stored.
module signed_cnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic             en,
  input  logic             down,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-2:0] step,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH:0]   nxt
);

  logic signed [WIDTH:0] q_x;
  logic signed [WIDTH:0] step_x;

  assign q_x    = {q[WIDTH-1], q};
  assign step_x = {2'b00, step};
  assign nxt    = down ? (q_x - step_x) : (q_x + step_x);

  // Count register: clear, load a new pass start, or advance by one step.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= nxt[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/signed_cnt_seq.sv
// Signed counter sequencer: runs start..end by step, rep passes, with
// pause/abort and busy/done/err status. Optional macro SIGNED_CNT_SEQ_DOWN_EN
// adds a dir input (1 = count down toward end).
// Handshake: start is a level request sampled only in IDLE; a program is
// accepted on the edge that moves to RUN (busy rises with the first q), and
// rejected programs give a one-cycle err pulse instead.
module signed_cnt_seq
  import signed_cnt_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
  input  logic [WIDTH-2:0] cfg_step,
  input  logic [REP_W-1:0] cfg_rep,
`ifdef SIGNED_CNT_SEQ_DOWN_EN
  input  logic             dir,
`endif
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REP_W-1:0] pass_cnt
);

  localparam int EXT = CMP_W - WIDTH - 1;

  state_t state_q, state_d;

  logic [WIDTH-1:0] start_l, end_l;
  logic [WIDTH-2:0] step_l;
  logic [REP_W-1:0] rep_l;
  logic             down_l;
  logic             dir_in;

  logic             load, en, latch;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH:0]   nxt;
  logic             busy_d, done_d, err_d;
  logic [REP_W-1:0] pass_d;

  logic signed [CMP_W-1:0] nxt_x, end_x, cs_x, ce_x;
  logic                    cfg_valid;

`ifdef SIGNED_CNT_SEQ_DOWN_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  assign nxt_x = {{EXT{nxt[WIDTH]}}, nxt};
  assign end_x = {{(EXT+1){end_l[WIDTH-1]}}, end_l};
  assign cs_x  = {{(EXT+1){cfg_start[WIDTH-1]}}, cfg_start};
  assign ce_x  = {{(EXT+1){cfg_end[WIDTH-1]}}, cfg_end};

  // A program is valid when its start is not already past its end.
  assign cfg_valid = !past_end(cs_x, ce_x, dir_in);

  signed_cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (load),
    .en       (en),
    .down     (down_l),
    .load_val (load_val),
    .step     (step_l),
    .q        (q),
    .nxt      (nxt)
  );

  // State and status registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pass_cnt <= '0;
    end else begin
      state_q  <= state_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      pass_cnt <= pass_d;
    end
  end

  // Program latch: captured once at acceptance so cfg_* may change freely
  // during a run. Zero step and zero repeat are stored as one.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      start_l <= '0;
      end_l   <= '0;
      step_l  <= '0;
      rep_l   <= '0;
      down_l  <= 1'b0;
    end else if (latch) begin
      start_l <= cfg_start;
      end_l   <= cfg_end;
      step_l  <= (cfg_step == '0) ? (WIDTH-1)'(1) : cfg_step;
      rep_l   <= (cfg_rep == '0) ? REP_W'(1) : cfg_rep;
      down_l  <= dir_in;
    end
  end

  // Next-state and counter control: abort beats pause beats counting; a pass
  // that would step past end either restarts at start or finishes the run.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    en       = 1'b0;
    latch    = 1'b0;
    load_val = start_l;
    busy_d   = busy;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pass_d   = pass_cnt;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_valid) begin
            latch    = 1'b1;
            load     = 1'b1;
            load_val = cfg_start;
            pass_d   = '0;
            busy_d   = 1'b1;
            state_d  = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (!pause) begin
          if (!past_end(nxt_x, end_x, down_l)) begin
            en = 1'b1;
          end else begin
            pass_d = pass_cnt + REP_W'(1);
            if (pass_d == rep_l) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              load = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_signed_cnt_seq.sv
// Self-checking bench for signed_cnt_seq; expected sequences come from a
// plain arithmetic model of the counting rules.
module tb_signed_cnt_seq;

  localparam int WIDTH = 4;
  localparam int REP_W = 3;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             start;
  logic [WIDTH-1:0] cfg_start;
  logic [WIDTH-1:0] cfg_end;
  logic [WIDTH-2:0] cfg_step;
  logic [REP_W-1:0] cfg_rep;
`ifdef SIGNED_CNT_SEQ_DOWN_EN
  logic             dir;
`endif
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             err;
  logic [REP_W-1:0] pass_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               pass_q[$];

  signed_cnt_seq #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .cfg_start (cfg_start),
    .cfg_end   (cfg_end),
    .cfg_step  (cfg_step),
    .cfg_rep   (cfg_rep),
`ifdef SIGNED_CNT_SEQ_DOWN_EN
    .dir       (dir),
`endif
    .pause     (pause),
    .abort     (abort),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pass_cnt  (pass_cnt)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  function automatic integer sv(input logic [WIDTH-1:0] x);
    return integer'($signed(x));
  endfunction

  task automatic chk(input string tag, input integer obs, input integer exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: list every value the counter shows, pass by pass.
  function automatic void build(input int s, input int e, input int st,
                                input int rp, input int dn);
    int stp, reps, v;
    stp  = (st == 0) ? 1 : st;
    reps = (rp == 0) ? 1 : rp;
    exp_q.delete();
    pass_q.delete();
    for (int p = 0; p < reps; p++) begin
      v = s;
      forever begin
        exp_q.push_back(v[WIDTH-1:0]);
        pass_q.push_back(p);
        if (dn != 0) begin
          if (v - stp < e) break;
          v = v - stp;
        end else begin
          if (v + stp > e) break;
          v = v + stp;
        end
      end
    end
  endfunction

  task automatic set_dir(input int dn);
`ifdef SIGNED_CNT_SEQ_DOWN_EN
    dir = (dn != 0);
`endif
  endtask

  task automatic drive_cfg(input int s, input int e, input int st, input int rp, input int dn);
    cfg_start = s[WIDTH-1:0];
    cfg_end   = e[WIDTH-1:0];
    cfg_step  = st[WIDTH-2:0];
    cfg_rep   = rp[REP_W-1:0];
    set_dir(dn);
  endtask

  task automatic noise();
    start     = 1'($urandom_range(0, 1));
    cfg_start = WIDTH'($urandom);
    cfg_end   = WIDTH'($urandom);
    cfg_step  = (WIDTH-1)'($urandom);
    cfg_rep   = REP_W'($urandom);
    set_dir(int'($urandom_range(0, 1)));
  endtask

  // Driver: run one valid program, optionally pausing or aborting after a
  // given value index, optionally scrambling cfg/start while busy.
  task automatic run_prog(input int s, input int e, input int st, input int rp,
                          input int dn, input int pause_idx, input int pause_len,
                          input int abort_idx, input bit scramble);
    logic [WIDTH-1:0] last;
    int lastp, idx, reps;
    reps = (rp == 0) ? 1 : rp;
    build(s, e, st, rp, dn);
    drive_cfg(s, e, st, rp, dn);
    pause = 1'b0;
    abort = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    last = '0;
    lastp = 0;
    while (exp_q.size() > 0) begin
      chk("run_q", sv(q), sv(exp_q[0]));
      chk("run_busy", busy, 1);
      chk("run_pass", pass_cnt, pass_q[0]);
      chk("run_done", done, 0);
      last  = exp_q.pop_front();
      lastp = pass_q.pop_front();
      if (idx == abort_idx) begin
        abort = 1'b1;
        pause = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        pause = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_q", sv(q), sv(last));
        chk("abort_pass", pass_cnt, lastp);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);
        chk("abort_idle_q", sv(q), sv(last));
        return;
      end
      if (idx == pause_idx) begin
        pause = 1'b1;
        for (int k = 0; k < pause_len; k++) begin
          @(posedge clk); #1;
          chk("pause_q", sv(q), sv(last));
          chk("pause_busy", busy, 1);
          chk("pause_pass", pass_cnt, lastp);
        end
        pause = 1'b0;
      end
      if (scramble) noise();
      @(posedge clk); #1;
      idx++;
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_q", sv(q), sv(last));
    chk("done_pass", pass_cnt, reps);
    // A request presented while in DONE must be ignored.
    drive_cfg(s, e, st, rp, dn);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_q", sv(q), sv(last));
    chk("post_pass", pass_cnt, reps);
  endtask

  // Driver: present a rejected program and expect a single err pulse.
  task automatic err_prog(input int s, input int e, input int dn);
    logic [WIDTH-1:0] prev;
    prev = q;
    drive_cfg(s, e, 1, 1, dn);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_q", sv(q), sv(prev));
    @(posedge clk); #1;
    chk("err_clear", err, 0);
    chk("err_idle_busy", busy, 0);
  endtask

  initial begin
    int s, e, st, rp, dn;
    clr_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    drive_cfg(0, 0, 0, 0, 0);
    #1;
    chk("rst_q", sv(q), 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pass", pass_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk); #1;

    // Basic run with step overshoot.
    run_prog(-3, 2, 2, 1, 0, -1, 0, -1, 1'b0);
    // Two passes with a three-cycle pause at q=-1.
    run_prog(-3, 2, 2, 2, 0, 1, 3, -1, 1'b0);
    // Full range, zero step and zero repeat.
    run_prog(-8, 7, 0, 0, 0, -1, 0, -1, 1'b0);
    // Single-value passes.
    run_prog(4, 4, 3, 3, 0, -1, 0, -1, 1'b0);
    // Rejected program.
    err_prog(3, -5, 0);
    // Abort (with pause also high) at q=0.
    run_prog(-2, 3, 1, 1, 0, -1, 0, 2, 1'b0);
    // Abort while IDLE does nothing.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_q", sv(q), 0);

`ifdef SIGNED_CNT_SEQ_DOWN_EN
    run_prog(5, -4, 3, 1, 1, -1, 0, -1, 1'b0);
    err_prog(-2, 3, 1);
`endif

    // Randomized valid programs with cfg/start scrambled while busy,
    // interleaved with randomized rejected programs.
    for (int n = 0; n < 24; n++) begin
      dn = 0;
`ifdef SIGNED_CNT_SEQ_DOWN_EN
      dn = int'($urandom_range(0, 1));
`endif
      s  = int'($urandom_range(0, 15)) - 8;
      if (dn != 0) e = s - int'($urandom_range(0, s + 8));
      else         e = s + int'($urandom_range(0, 7 - s));
      st = int'($urandom_range(0, 7));
      rp = int'($urandom_range(0, 3));
      run_prog(s, e, st, rp, dn, -1, 0, -1, 1'b1);
      if ((n % 4) == 3) begin
        s = int'($urandom_range(0, 14)) - 7;
        if (dn != 0) e = s + 1 + int'($urandom_range(0, 7 - s - 1 + 0));
        else         e = s - 1 - int'($urandom_range(0, s + 7));
        if (e > 7) e = 7;
        if (dn != 0 && e <= s) e = s + 1;
        if (dn != 0 && s == 7) begin
          s = 6;
          e = 7;
        end
        err_prog(s, e, dn);
      end
    end

    // Asynchronous clear in the middle of a run (q=2, one pass complete).
    drive_cfg(2, 3, 1, 3, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_clr_q", sv(q), 2);
    chk("pre_clr_pass", pass_cnt, 1);
    #1;
    clr_n = 1'b0;
    #1;
    chk("clr_q", sv(q), 0);
    chk("clr_busy", busy, 0);
    chk("clr_pass", pass_cnt, 0);
    chk("clr_done", done, 0);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk); #1;
    chk("after_clr_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
